// File: rtl/ifm_buf_pkg.sv
// Shared FSM encodings, tag bit offsets and config normalisation for the IFM window buffer.
package ifm_buf_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE    = 3'd0;
  localparam state_t FILL    = 3'd1;
  localparam state_t READ    = 3'd2;
  localparam state_t ADVANCE = 3'd3;
  localparam state_t FLUSH   = 3'd4;

  // Tag bits sit directly above the data lanes of a write beat.
  localparam int SOT_BIT_OFS = 1;
  localparam int EOT_BIT_OFS = 0;

  function automatic int clamp_cfg(input int val, input int max_val);
    if (val == 0) return 1;
    if (val > max_val) return max_val;
    return val;
  endfunction

endpackage

// File: rtl/ifm_window_buf_if.sv
// Handshake/bus bundle between the IFM window buffer and its producer/consumer.
// Status signals exist only when IFM_BUF_STATUS_EN is defined.
interface ifm_window_buf_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int PAR_WRITE  = 1,
  parameter int PAR_READ   = 1,
  parameter int S          = 3,
  parameter int F          = 4
);
  logic                              start;
  logic [S-1:0]                      stride;
  logic [F-1:0]                      filter_size;
  logic                              w_en;
  logic [DATA_WIDTH*PAR_WRITE+1:0]   data_in;
  logic                              ready;
  logic                              r_en;
  logic [DATA_WIDTH*PAR_READ-1:0]    data_out;
  logic                              valid;
  logic                              win_done;
  logic                              row_done;
`ifdef IFM_BUF_STATUS_EN
  logic [ADDR_WIDTH:0]               occupancy;
  logic                              err_overflow;
  logic                              err_tag;
`endif

  modport master (
    output start, stride, filter_size, w_en, data_in, r_en,
    input  ready, data_out, valid, win_done, row_done
`ifdef IFM_BUF_STATUS_EN
    , input occupancy, err_overflow, err_tag
`endif
  );

  modport slave (
    input  start, stride, filter_size, w_en, data_in, r_en,
    output ready, data_out, valid, win_done, row_done
`ifdef IFM_BUF_STATUS_EN
    , output occupancy, err_overflow, err_tag
`endif
  );
endinterface

// File: rtl/ifm_buf_mem.sv
// DEPTH-entry element store: PAR_WRITE consecutive write lanes, PAR_READ wrapped read lanes.
module ifm_buf_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int PAR_WRITE  = 1,
  parameter int PAR_READ   = 1
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [ADDR_WIDTH-1:0]          waddr,
  input  logic [DATA_WIDTH*PAR_WRITE-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0]          raddr,
  output logic [DATA_WIDTH*PAR_READ-1:0] rdata
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      for (int i = 0; i < PAR_WRITE; i++)
        mem_d[waddr + ADDR_WIDTH'(i)] = wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;

  // Address arithmetic is ADDR_WIDTH wide, so windows straddling the end wrap naturally.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < PAR_READ; i++)
      rdata[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[raddr + ADDR_WIDTH'(i)];
  end
endmodule

// File: rtl/ifm_window_buf.sv
// Sliding-window IFM scratchpad: tagged rows in, filter_size-long windows out, stepping by stride.
// Optional status outputs (occupancy, err_overflow, err_tag) when IFM_BUF_STATUS_EN is defined.
module ifm_window_buf
  import ifm_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int PAR_WRITE  = 1,
  parameter int PAR_READ   = 1,
  parameter int S          = 3,
  parameter int F          = 4
) (
  input logic             clk,
  input logic             rst,
  ifm_window_buf_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LW    = DATA_WIDTH * PAR_WRITE;

  typedef logic [ADDR_WIDTH:0] ptr_t;

  state_t state_q, state_d;
  ptr_t   wptr_q, wptr_d, base_q, base_d, off_q, off_d;
  ptr_t   end_ptr_q, end_ptr_d, fs_q, fs_d;
  logic [S-1:0] stride_q, stride_d;
  logic   end_seen_q, end_seen_d;
  logic [DATA_WIDTH*PAR_READ-1:0] data_out_q, data_out_d, rd_data;
  logic   valid_q, valid_d, win_done_q, win_done_d, row_done_q, row_done_d;

  ptr_t   count, row_len;
  logic   ready, accept, eot;
  logic [ADDR_WIDTH-1:0] rd_addr;

  assign count   = wptr_q - base_q;
  assign row_len = end_ptr_q + ptr_t'(1) - base_q;
  assign ready   = (state_q != IDLE) && !end_seen_q && (DEPTH - int'(count) >= PAR_WRITE);
  assign accept  = bus.w_en && ready && !bus.start;
  assign eot     = bus.data_in[LW + EOT_BIT_OFS];
  assign rd_addr = base_q[ADDR_WIDTH-1:0] + off_q[ADDR_WIDTH-1:0];

  ifm_buf_mem #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
    .PAR_WRITE(PAR_WRITE),   .PAR_READ(PAR_READ)
  ) u_mem (
    .clk   (clk),
    .we    (accept),
    .waddr (wptr_q[ADDR_WIDTH-1:0]),
    .wdata (bus.data_in[LW-1:0]),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    base_d     = base_q;
    off_d      = off_q;
    end_ptr_d  = end_ptr_q;
    end_seen_d = end_seen_q;
    fs_d       = fs_q;
    stride_d   = stride_q;
    valid_d    = 1'b0;
    win_done_d = 1'b0;
    row_done_d = 1'b0;
    data_out_d = '0;
    if (bus.start) begin
      state_d    = FILL;
      wptr_d     = '0;
      base_d     = '0;
      off_d      = '0;
      end_ptr_d  = '0;
      end_seen_d = 1'b0;
      fs_d       = ptr_t'(clamp_cfg(int'(bus.filter_size), DEPTH));
      stride_d   = S'(clamp_cfg(int'(bus.stride), (1 << S) - 1));
    end else begin
      if (accept) begin
        wptr_d = wptr_q + ptr_t'(PAR_WRITE);
        if (eot) begin
          end_seen_d = 1'b1;
          end_ptr_d  = wptr_q + ptr_t'(PAR_WRITE - 1);
        end
      end
      case (state_q)
        FILL: begin
          if (int'(count) >= int'(fs_q))
            state_d = READ;
          else if (end_seen_q && int'(row_len) < int'(fs_q))
            state_d = FLUSH;
        end
        READ: begin
          if (bus.r_en) begin
            valid_d = 1'b1;
            for (int i = 0; i < PAR_READ; i++)
              if (int'(off_q) + i < int'(fs_q))
                data_out_d[i*DATA_WIDTH +: DATA_WIDTH] = rd_data[i*DATA_WIDTH +: DATA_WIDTH];
            if (int'(off_q) + PAR_READ >= int'(fs_q)) begin
              win_done_d = 1'b1;
              off_d      = '0;
              state_d    = ADVANCE;
            end else begin
              off_d = off_q + ptr_t'(PAR_READ);
            end
          end
        end
        // Decide from the pre-advance pointers whether another full window remains in this row.
        ADVANCE: begin
          base_d = base_q + ptr_t'(stride_q);
          if (end_seen_q && int'(stride_q) + int'(fs_q) > int'(row_len))
            state_d = FLUSH;
          else if (int'(count) - int'(stride_q) >= int'(fs_q))
            state_d = READ;
          else
            state_d = FILL;
        end
        FLUSH: begin
          base_d     = end_ptr_q + ptr_t'(1);
          end_seen_d = 1'b0;
          row_done_d = 1'b1;
          state_d    = FILL;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      base_q     <= '0;
      off_q      <= '0;
      end_ptr_q  <= '0;
      end_seen_q <= 1'b0;
      fs_q       <= '0;
      stride_q   <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      win_done_q <= 1'b0;
      row_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      base_q     <= base_d;
      off_q      <= off_d;
      end_ptr_q  <= end_ptr_d;
      end_seen_q <= end_seen_d;
      fs_q       <= fs_d;
      stride_q   <= stride_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      win_done_q <= win_done_d;
      row_done_q <= row_done_d;
    end
  end

  assign bus.ready    = ready;
  assign bus.data_out = data_out_q;
  assign bus.valid    = valid_q;
  assign bus.win_done = win_done_q;
  assign bus.row_done = row_done_q;

`ifdef IFM_BUF_STATUS_EN
  logic sot;
  logic err_overflow_q, err_overflow_d, err_tag_q, err_tag_d, expect_sot_q, expect_sot_d;

  assign sot = bus.data_in[LW + SOT_BIT_OFS];

  // The first accepted beat of every row must carry the start tag, and no later beat may.
  always_comb begin
    err_overflow_d = err_overflow_q;
    err_tag_d      = err_tag_q;
    expect_sot_d   = expect_sot_q;
    if (bus.start) begin
      err_overflow_d = 1'b0;
      err_tag_d      = 1'b0;
      expect_sot_d   = 1'b1;
    end else begin
      if (bus.w_en && !ready) err_overflow_d = 1'b1;
      if (accept) begin
        if (sot != expect_sot_q) err_tag_d = 1'b1;
        expect_sot_d = 1'b0;
      end
      if (state_q == FLUSH) expect_sot_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_overflow_q <= 1'b0;
      err_tag_q      <= 1'b0;
      expect_sot_q   <= 1'b0;
    end else begin
      err_overflow_q <= err_overflow_d;
      err_tag_q      <= err_tag_d;
      expect_sot_q   <= expect_sot_d;
    end
  end

  assign bus.occupancy    = count;
  assign bus.err_overflow = err_overflow_q;
  assign bus.err_tag      = err_tag_q;
`endif
endmodule

// File: tb/tb_ifm_window_buf.sv
// Directed bench for ifm_window_buf: scoreboard of expected window beats, two configurations.
module tb_ifm_window_buf;

  typedef struct packed {
    logic [31:0] data;
    logic        wd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  exp_t q1[$];
  exp_t q2[$];
  int   v1_beats = 0, wd1 = 0, rd1 = 0;
  int   v2_beats = 0, wd2 = 0, rd2 = 0;

  always #5 clk = ~clk;

  ifm_window_buf_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .PAR_WRITE(1), .PAR_READ(1), .S(3), .F(4)) b1 ();
  ifm_window_buf_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .PAR_WRITE(1), .PAR_READ(2), .S(3), .F(4)) b2 ();

  ifm_window_buf #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .PAR_WRITE(1), .PAR_READ(1), .S(3), .F(4)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  ifm_window_buf #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .PAR_WRITE(1), .PAR_READ(2), .S(3), .F(4)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (b2)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic startRun(input int which, input logic [2:0] stride, input logic [3:0] fs);
    @(negedge clk);
    if (which == 1) begin
      b1.stride = stride; b1.filter_size = fs; b1.start = 1'b1;
    end else begin
      b2.stride = stride; b2.filter_size = fs; b2.start = 1'b1;
    end
    @(negedge clk);
    b1.start = 1'b0;
    b2.start = 1'b0;
  endtask

  // One write beat: driven at a negedge, taken at the following posedge if ready.
  task automatic applyStimulus(input int which, input logic sot, input logic eot,
                               input logic [15:0] d, output logic acc);
    @(negedge clk);
    if (which == 1) begin
      b1.w_en = 1'b1; b1.data_in = {sot, eot, d}; acc = b1.ready;
    end else begin
      b2.w_en = 1'b1; b2.data_in = {sot, eot, d}; acc = b2.ready;
    end
  endtask

  task automatic waitRowDone(input int which, input int limit, output logic seen);
    seen = 1'b0;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      b1.w_en = 1'b0;
      b2.w_en = 1'b0;
      seen = (which == 1) ? b1.row_done : b2.row_done;
      if (seen) break;
    end
  endtask

  task automatic writeRow(input int which, input int len, input logic [15:0] base_val,
                          input logic with_eot, output int acc_n);
    logic acc;
    acc_n = 0;
    for (int i = 0; i < len; i++) begin
      applyStimulus(which, i == 0, with_eot && (i == len - 1), base_val + 16'(i), acc);
      if (acc) acc_n++;
    end
  endtask

  task automatic pushWindows1(input int len, input int fs, input int st, input logic [15:0] base_val);
    exp_t e;
    for (int b = 0; b + fs <= len; b += st)
      for (int o = 0; o < fs; o++) begin
        e.data = 32'(base_val + 16'(b + o));
        e.wd   = (o == fs - 1);
        q1.push_back(e);
      end
  endtask

  task automatic pushWindows2(input int len, input int fs, input int st, input logic [15:0] base_val);
    exp_t e;
    logic [15:0] l0, l1;
    for (int b = 0; b + fs <= len; b += st)
      for (int o = 0; o < fs; o += 2) begin
        l0     = base_val + 16'(b + o);
        l1     = (o + 1 < fs) ? base_val + 16'(b + o + 1) : 16'h0;
        e.data = {l1, l0};
        e.wd   = (o + 2 >= fs);
        q2.push_back(e);
      end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (b1.valid) begin
        v1_beats++;
        if (q1.size() == 0) checkOutput("dut1_spurious_valid", 64'(b1.valid), 64'd0);
        else begin
          e = q1.pop_front();
          checkOutput("dut1_data", 64'(b1.data_out), 64'(e.data));
          checkOutput("dut1_win_done", 64'(b1.win_done), 64'(e.wd));
        end
      end
      if (b1.win_done) wd1++;
      if (b1.row_done) rd1++;
      if (b2.valid) begin
        v2_beats++;
        if (q2.size() == 0) checkOutput("dut2_spurious_valid", 64'(b2.valid), 64'd0);
        else begin
          e = q2.pop_front();
          checkOutput("dut2_data", 64'(b2.data_out), 64'(e.data));
          checkOutput("dut2_win_done", 64'(b2.win_done), 64'(e.wd));
        end
      end
      if (b2.win_done) wd2++;
      if (b2.row_done) rd2++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog_timeout");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int   acc_n, v0, w0, r0;
    logic seen;

    b1.start = 0; b1.stride = 0; b1.filter_size = 0; b1.w_en = 0; b1.data_in = '0; b1.r_en = 0;
    b2.start = 0; b2.stride = 0; b2.filter_size = 0; b2.w_en = 0; b2.data_in = '0; b2.r_en = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_valid", 64'(b1.valid), 64'd0);
    checkOutput("reset_ready", 64'(b1.ready), 64'd0);
    checkOutput("reset_win_done", 64'(b1.win_done), 64'd0);
    checkOutput("reset_row_done", 64'(b1.row_done), 64'd0);
    checkOutput("reset_data_out", 64'(b1.data_out), 64'd0);

    $display("[TB] fs=3 stride=1 row of 10");
    startRun(1, 3'd1, 4'd3);
    b1.r_en = 1'b1;
    v0 = v1_beats; w0 = wd1; r0 = rd1;
    pushWindows1(10, 3, 1, 16'hA000);
    writeRow(1, 10, 16'hA000, 1'b1, acc_n);
    checkOutput("t1_accepted", 64'(acc_n), 64'd10);
    waitRowDone(1, 200, seen);
    checkOutput("t1_row_done", 64'(seen), 64'd1);
    checkOutput("t1_queue_empty_at_row_done", 64'(q1.size()), 64'd0);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("t1_valid_beats", 64'(v1_beats - v0), 64'd24);
    checkOutput("t1_win_done_count", 64'(wd1 - w0), 64'd8);
    checkOutput("t1_row_done_count", 64'(rd1 - r0), 64'd1);
`ifdef IFM_BUF_STATUS_EN
    checkOutput("t1_err_tag", 64'(b1.err_tag), 64'd0);
`endif
    b1.r_en = 1'b0;

    $display("[TB] fs=3 stride=2 row of 9");
    startRun(1, 3'd2, 4'd3);
    b1.r_en = 1'b1;
    v0 = v1_beats; w0 = wd1; r0 = rd1;
    pushWindows1(9, 3, 2, 16'hB000);
    writeRow(1, 9, 16'hB000, 1'b1, acc_n);
    waitRowDone(1, 200, seen);
    checkOutput("t2_row_done", 64'(seen), 64'd1);
    checkOutput("t2_ready_after_flush", 64'(b1.ready), 64'd1);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("t2_valid_beats", 64'(v1_beats - v0), 64'd12);
    checkOutput("t2_win_done_count", 64'(wd1 - w0), 64'd4);
    checkOutput("t2_row_done_count", 64'(rd1 - r0), 64'd1);
    checkOutput("t2_queue_empty", 64'(q1.size()), 64'd0);
    b1.r_en = 1'b0;

    $display("[TB] fs=3 short row of 2");
    startRun(1, 3'd1, 4'd3);
    b1.r_en = 1'b1;
    v0 = v1_beats;
    writeRow(1, 2, 16'hD000, 1'b1, acc_n);
    waitRowDone(1, 3, seen);
    checkOutput("t3_row_done_within_2", 64'(seen), 64'd1);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("t3_no_valid", 64'(v1_beats - v0), 64'd0);
    b1.r_en = 1'b0;

    $display("[TB] fs=15 overflow, 20 beats no reads");
    startRun(1, 3'd1, 4'd15);
    writeRow(1, 20, 16'hC000, 1'b0, acc_n);
    @(negedge clk);
    b1.w_en = 1'b0;
    checkOutput("t4_accepted", 64'(acc_n), 64'd16);
    checkOutput("t4_ready_low_when_full", 64'(b1.ready), 64'd0);
`ifdef IFM_BUF_STATUS_EN
    checkOutput("t4_occupancy", 64'(b1.occupancy), 64'd16);
    checkOutput("t4_err_overflow", 64'(b1.err_overflow), 64'd1);
    checkOutput("t4_err_tag", 64'(b1.err_tag), 64'd0);
`endif

    $display("[TB] reset during READ");
    startRun(1, 3'd1, 4'd3);
    b1.r_en = 1'b1;
    pushWindows1(6, 3, 1, 16'h5000);
    writeRow(1, 6, 16'h5000, 1'b0, acc_n);
    @(negedge clk);
    b1.w_en = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if (b1.valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("t6_valid_seen", 64'(seen), 64'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_valid_async_drop", 64'(b1.valid), 64'd0);
    checkOutput("t6_win_done_async_drop", 64'(b1.win_done), 64'd0);
    checkOutput("t6_ready_after_rst", 64'(b1.ready), 64'd0);
    q1.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    startRun(1, 3'd1, 4'd3);
    v0 = v1_beats; r0 = rd1;
    pushWindows1(4, 3, 1, 16'h6000);
    writeRow(1, 4, 16'h6000, 1'b1, acc_n);
    waitRowDone(1, 200, seen);
    checkOutput("t6_row_done", 64'(seen), 64'd1);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("t6_valid_beats", 64'(v1_beats - v0), 64'd6);
    checkOutput("t6_queue_empty", 64'(q1.size()), 64'd0);
    b1.r_en = 1'b0;

    $display("[TB] PAR_READ=2 fs=3 row of 5");
    startRun(2, 3'd1, 4'd3);
    b2.r_en = 1'b1;
    v0 = v2_beats; w0 = wd2; r0 = rd2;
    pushWindows2(5, 3, 1, 16'h7000);
    writeRow(2, 5, 16'h7000, 1'b1, acc_n);
    waitRowDone(2, 200, seen);
    checkOutput("t5_row_done", 64'(seen), 64'd1);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("t5_valid_beats", 64'(v2_beats - v0), 64'd6);
    checkOutput("t5_win_done_count", 64'(wd2 - w0), 64'd3);
    checkOutput("t5_row_done_count", 64'(rd2 - r0), 64'd1);
    checkOutput("t5_queue_empty", 64'(q2.size()), 64'd0);
    b2.r_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
